// File: rtl/rs_multi_pkg.sv
// Shared core widths, FU-select encoding and the reservation-station entry type.
package rs_multi_pkg;

    localparam int PRF_IDX_W = 6;
    localparam int ROB_IDX_W = 5;
    localparam int BR_MASK_W = 4;
    localparam int FU_SEL_W  = 3;

    localparam logic [FU_SEL_W-1:0] FU_SEL_NONE = 3'b111;

    typedef struct packed {
        logic                 valid;
        logic [PRF_IDX_W-1:0] opa_tag;
        logic                 opa_rdy;
        logic [PRF_IDX_W-1:0] opb_tag;
        logic                 opb_rdy;
        logic [PRF_IDX_W-1:0] dest_tag;
        logic [FU_SEL_W-1:0]  fu_sel;
        logic [31:0]          ir;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [BR_MASK_W-1:0] br_mask;
    } rs_entry_t;

endpackage

// File: rtl/rs_psel.sv
// One-hot issue selector: oldest requester when RS_AGE_SEL_EN is defined,
// otherwise the lowest-index requester.
module rs_psel #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req_i,
`ifdef RS_AGE_SEL_EN
    input  logic [N-1:0][N-1:0]  older_i,
`endif
    output logic [N-1:0]         gnt_o
);

`ifdef RS_AGE_SEL_EN
    logic [N-1:0] blocked;

    // older_i[j][k] means entry j was dispatched before entry k.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        gnt_o   = '0;
        blocked = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                blocked[k] = blocked[k] | (req_i[j] & older_i[j][k]);
            end
            gnt_o[k] = req_i[k] & ~blocked[k];
        end
    end
`else
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (req_i[k] && !found) begin
                gnt_o[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/rs_multi.sv
// Multi-entry reservation station with CDB bypass wakeup and branch-mask squash.
// Define RS_AGE_SEL_EN for oldest-first select; default is lowest-index select.
module rs_multi
    import rs_multi_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int CDB_NUM  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rs_dp_en_i,
    input  logic [PRF_IDX_W-1:0]            rs_dp_opa_tag_i,
    input  logic [PRF_IDX_W-1:0]            rs_dp_opb_tag_i,
    input  logic                            rs_dp_opa_rdy_i,
    input  logic                            rs_dp_opb_rdy_i,
    input  logic [PRF_IDX_W-1:0]            rs_dp_dest_tag_i,
    input  logic [FU_SEL_W-1:0]             rs_dp_fu_sel_i,
    input  logic [31:0]                     rs_dp_IR_i,
    input  logic [ROB_IDX_W-1:0]            rs_dp_rob_idx_i,
    input  logic [BR_MASK_W-1:0]            rs_dp_br_mask_i,
    input  logic [CDB_NUM-1:0]              rs_cdb_vld_i,
    input  logic [CDB_NUM*PRF_IDX_W-1:0]    rs_cdb_tag_i,
    input  logic                            rs_br_pred_correct_i,
    input  logic                            rs_br_recovery_i,
    input  logic [BR_MASK_W-1:0]            rs_br_tag_fix_i,
    input  logic                            rs_iss_rdy_i,
    output logic                            rs_iss_vld_o,
    output logic [PRF_IDX_W-1:0]            rs_iss_opa_tag_o,
    output logic [PRF_IDX_W-1:0]            rs_iss_opb_tag_o,
    output logic [PRF_IDX_W-1:0]            rs_iss_dest_tag_o,
    output logic [FU_SEL_W-1:0]             rs_iss_fu_sel_o,
    output logic [31:0]                     rs_iss_IR_o,
    output logic [ROB_IDX_W-1:0]            rs_iss_rob_idx_o,
    output logic [BR_MASK_W-1:0]            rs_iss_br_mask_o,
    output logic                            rs_full_o,
    output logic [$clog2(RS_DEPTH):0]       rs_cnt_o
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    function automatic logic cdb_hit(input logic [PRF_IDX_W-1:0]         tag,
                                     input logic [CDB_NUM-1:0]           vld,
                                     input logic [CDB_NUM*PRF_IDX_W-1:0] tags);
        logic hit = 1'b0;
        for (int p = 0; p < CDB_NUM; p++) begin
            hit = hit | (vld[p] & (tags[p*PRF_IDX_W +: PRF_IDX_W] == tag));
        end
        return hit;
    endfunction

    rs_entry_t           entries_q [RS_DEPTH];
    rs_entry_t           entries_d [RS_DEPTH];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RS_DEPTH-1:0] req, squash, gnt;
    logic [IDX_W-1:0]    free_idx;
    logic [BR_MASK_W-1:0] clear_mask;
    rs_entry_t           iss_e, dp_e;
    logic                dp_wr, issue_fire;

    assign clear_mask = rs_br_pred_correct_i ? rs_br_tag_fix_i : '0;
    assign rs_full_o  = (cnt_q == CNT_W'(RS_DEPTH));
    assign rs_cnt_o   = cnt_q;

    // Ready includes same-cycle CDB matches; squashed entries never request.
    always_comb begin
        req    = '0;
        squash = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            squash[i] = entries_q[i].valid & rs_br_recovery_i &
                        (|(entries_q[i].br_mask & rs_br_tag_fix_i));
            req[i]    = entries_q[i].valid & ~squash[i] & ~rst &
                        (entries_q[i].opa_rdy | cdb_hit(entries_q[i].opa_tag, rs_cdb_vld_i, rs_cdb_tag_i)) &
                        (entries_q[i].opb_rdy | cdb_hit(entries_q[i].opb_tag, rs_cdb_vld_i, rs_cdb_tag_i));
        end
    end

`ifdef RS_AGE_SEL_EN
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;

    rs_psel #(.N(RS_DEPTH)) u_psel (.req_i(req), .older_i(older_q), .gnt_o(gnt));
`else
    rs_psel #(.N(RS_DEPTH)) u_psel (.req_i(req), .gnt_o(gnt));
`endif

    always_comb begin
        iss_e = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (gnt[i]) iss_e = iss_e | entries_q[i];
        end
    end

    assign rs_iss_vld_o      = |gnt;
    assign issue_fire        = rs_iss_vld_o & rs_iss_rdy_i;
    assign rs_iss_opa_tag_o  = iss_e.opa_tag;
    assign rs_iss_opb_tag_o  = iss_e.opb_tag;
    assign rs_iss_dest_tag_o = iss_e.dest_tag;
    assign rs_iss_fu_sel_o   = rs_iss_vld_o ? iss_e.fu_sel : FU_SEL_NONE;
    assign rs_iss_IR_o       = iss_e.ir;
    assign rs_iss_rob_idx_o  = iss_e.rob_idx;
    assign rs_iss_br_mask_o  = iss_e.br_mask & ~clear_mask;

    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) free_idx = IDX_W'(i);
        end
    end

    assign dp_wr = rs_dp_en_i & ~rs_full_o &
                   ~(rs_br_recovery_i & (|(rs_dp_br_mask_i & rs_br_tag_fix_i)));

    always_comb begin
        dp_e          = '0;
        dp_e.valid    = 1'b1;
        dp_e.opa_tag  = rs_dp_opa_tag_i;
        dp_e.opa_rdy  = rs_dp_opa_rdy_i | cdb_hit(rs_dp_opa_tag_i, rs_cdb_vld_i, rs_cdb_tag_i);
        dp_e.opb_tag  = rs_dp_opb_tag_i;
        dp_e.opb_rdy  = rs_dp_opb_rdy_i | cdb_hit(rs_dp_opb_tag_i, rs_cdb_vld_i, rs_cdb_tag_i);
        dp_e.dest_tag = rs_dp_dest_tag_i;
        dp_e.fu_sel   = rs_dp_fu_sel_i;
        dp_e.ir       = rs_dp_IR_i;
        dp_e.rob_idx  = rs_dp_rob_idx_i;
        dp_e.br_mask  = rs_dp_br_mask_i & ~clear_mask;
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].valid) begin
                entries_d[i].opa_rdy = entries_q[i].opa_rdy | cdb_hit(entries_q[i].opa_tag, rs_cdb_vld_i, rs_cdb_tag_i);
                entries_d[i].opb_rdy = entries_q[i].opb_rdy | cdb_hit(entries_q[i].opb_tag, rs_cdb_vld_i, rs_cdb_tag_i);
                entries_d[i].br_mask = entries_q[i].br_mask & ~clear_mask;
                if (squash[i] || (issue_fire && gnt[i])) entries_d[i].valid = 1'b0;
            end
            if (dp_wr && free_idx == IDX_W'(i)) entries_d[i] = dp_e;
        end
    end

    assign cnt_d = cnt_q + CNT_W'(dp_wr) - CNT_W'(issue_fire) - CNT_W'($countones(squash));

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            cnt_q <= '0;
            // NOTE: only the valid bits are reset; payload is don't-care while invalid.
            for (int i = 0; i < RS_DEPTH; i++) entries_q[i].valid <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < RS_DEPTH; i++) entries_q[i] <= entries_d[i];
        end
    end

`ifdef RS_AGE_SEL_EN
    // New entry k is younger than every live entry and older than none.
    always_comb begin
        older_d = older_q;
        if (dp_wr) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                older_d[free_idx][j] = 1'b0;
                older_d[j][free_idx] = entries_q[j].valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) older_q <= '0;
        else     older_q <= older_d;
    end
`endif

    dp_when_full_a: assert property (@(posedge clk) disable iff (rst) !(rs_dp_en_i && rs_full_o));

endmodule
